// File: rtl/kolibri_spi_pkg.sv
// kolibri_spi_pkg: register map, bit positions and state encoding shared by the SPI target
package kolibri_spi_pkg;
  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam int ST_RXF = 0;
  localparam int ST_TXE = 1;
  localparam int ST_OVR = 2;
  localparam int ST_SEL = 3;
  localparam int CT_RX  = 0;
  localparam int CT_TX  = 1;
  localparam int CT_OVR = 2;
  localparam logic [7:0] DUMMY_DEF = 8'hFF;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/spi_target_if.sv
// spi_target_if: SPI pins plus CPU strobe bus of the SPI target
interface spi_target_if;
  logic       SCLK_IN, nSS, MOSI_IN, MISO, MISO_OE;
  logic [1:0] ADDR;
  logic       WR_STB, RD_STB, IRQ;
  logic [7:0] WDATA, RDATA;
  modport slave (input SCLK_IN, nSS, MOSI_IN, ADDR, WR_STB, RD_STB, WDATA,
                 output MISO, MISO_OE, RDATA, IRQ);
  modport master (output SCLK_IN, nSS, MOSI_IN, ADDR, WR_STB, RD_STB, WDATA,
                  input MISO, MISO_OE, RDATA, IRQ);
endinterface

// File: rtl/spi_sync.sv
// spi_sync: multi-stage synchronizer followed by a rise/fall edge detector
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end
  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;
endmodule

// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target exchanging bytes with the CPU through a four-register window
module spi_target
  import kolibri_spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DUMMY       = DUMMY_DEF
) (
  input logic       MHZ48,
  input logic       nRES,
  spi_target_if.slave bus
);
  logic       sclk_rise, sclk_fall, nss_s, nss_rise, nss_fall, mosi_s;
  logic [2:0] sync_unused;
  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d, ien_q;
  logic [7:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d, tx_buf_q, tx_buf_d;
  logic [7:0] tx_shift_q, tx_shift_d, rdata_q, status_v, rd_mux, rx_byte, tx_next;
  logic       rx_full_q, rx_full_d, ovr_q, ovr_d, tx_valid_q, tx_valid_d;
  logic       miso_q, miso_oe_q, irq_q, reload, rd_data, wr_data, wr_ovr, wr_ctrl;
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (.clk(MHZ48), .rst_n(nRES),
    .d_i(bus.SCLK_IN), .q_o(sync_unused[0]), .rise_o(sclk_rise), .fall_o(sclk_fall));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_nss (.clk(MHZ48), .rst_n(nRES),
    .d_i(bus.nSS), .q_o(nss_s), .rise_o(nss_rise), .fall_o(nss_fall));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (.clk(MHZ48), .rst_n(nRES),
    .d_i(bus.MOSI_IN), .q_o(mosi_s), .rise_o(sync_unused[1]), .fall_o(sync_unused[2]));
  assign rd_data = bus.RD_STB && bus.ADDR == A_DATA;
  assign wr_data = bus.WR_STB && bus.ADDR == A_DATA;
  assign wr_ovr  = bus.WR_STB && bus.ADDR == A_STATUS && bus.WDATA[ST_OVR];
  assign wr_ctrl = bus.WR_STB && bus.ADDR == A_CTRL;
  assign rx_byte = {rx_shift_q[6:0], mosi_s};
  assign tx_next = tx_valid_q ? tx_buf_q : DUMMY;
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_full_d  = rd_data ? 1'b0 : rx_full_q;
    ovr_d      = wr_ovr ? 1'b0 : ovr_q;
    tx_shift_d = tx_shift_q;
    reload     = 1'b0;
    if (nss_rise) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
    end else if (state_q == IDLE && nss_fall) begin
      state_d    = SHIFT;
      tx_shift_d = tx_next;
      reload     = 1'b1;
    end else if (state_q == SHIFT && sclk_rise) begin
      rx_shift_d = rx_byte;
      bit_cnt_d  = bit_cnt_q + 3'd1;
      // a completing byte beats a same-cycle DATA read; otherwise a full buffer drops it
      if (bit_cnt_q == 3'd7) begin
        if (rx_full_q && !rd_data) ovr_d = 1'b1;
        else begin
          rx_data_d = rx_byte;
          rx_full_d = 1'b1;
        end
      end
    end else if (state_q == SHIFT && sclk_fall) begin
      reload     = bit_cnt_q == 3'd0;
      tx_shift_d = reload ? tx_next : {tx_shift_q[6:0], 1'b0};
    end
    tx_valid_d = wr_data | (tx_valid_q & ~reload);
    tx_buf_d   = wr_data ? bus.WDATA : tx_buf_q;
  end
  always_comb begin
    status_v         = '0;
    status_v[ST_RXF] = rx_full_q;
    status_v[ST_TXE] = ~tx_valid_q;
    status_v[ST_OVR] = ovr_q;
    status_v[ST_SEL] = ~nss_s;
    rd_mux = bus.ADDR == A_DATA   ? rx_data_q :
             bus.ADDR == A_STATUS ? status_v :
             bus.ADDR == A_CTRL   ? {5'b0, ien_q} : 8'h00;
  end
  always_ff @(posedge MHZ48 or negedge nRES) begin
    if (!nRES) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_full_q  <= 1'b0;
      ovr_q      <= 1'b0;
      tx_buf_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_shift_q <= '0;
      ien_q      <= '0;
      miso_q     <= 1'b1;
      miso_oe_q  <= 1'b0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_full_q  <= rx_full_d;
      ovr_q      <= ovr_d;
      tx_buf_q   <= tx_buf_d;
      tx_valid_q <= tx_valid_d;
      tx_shift_q <= tx_shift_d;
      ien_q      <= wr_ctrl ? bus.WDATA[2:0] : ien_q;
      miso_q     <= state_d == SHIFT ? tx_shift_d[7] : 1'b1;
      miso_oe_q  <= state_d == SHIFT;
      rdata_q    <= bus.RD_STB ? rd_mux : rdata_q;
      irq_q      <= (rx_full_q & ien_q[CT_RX]) | (~tx_valid_q & ien_q[CT_TX]) |
                    (ovr_q & ien_q[CT_OVR]);
    end
  end
  assign bus.MISO    = miso_q;
  assign bus.MISO_OE = miso_oe_q;
  assign bus.RDATA   = rdata_q;
  assign bus.IRQ     = irq_q;
endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: scenario tasks drive the SPI master and CPU bus, scoreboard queues hold expected bytes
module tb_spi_target;
  import kolibri_spi_pkg::*;
  localparam int LAT = 3;
  logic clk = 1'b0, rst_n = 1'b1;
  int checks = 0, errors = 0;
  logic [7:0] miso_exp[$], rx_exp[$];
  spi_target_if bus();
  spi_target #(.SYNC_STAGES(2), .DUMMY(8'hFF)) dut (.MHZ48(clk), .nRES(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    bus.ADDR = a; bus.WDATA = d; bus.WR_STB = 1'b1;
    tick(1);
    bus.WR_STB = 1'b0;
  endtask
  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    bus.ADDR = a; bus.RD_STB = 1'b1;
    tick(1);
    bus.RD_STB = 1'b0;
    d = bus.RDATA;
  endtask
  task automatic bit_rise(input logic b, output logic m);
    bus.MOSI_IN = b;
    tick(8);
    m = bus.MISO;
    bus.SCLK_IN = 1'b1;
  endtask
  task automatic bit_fall;
    tick(8);
    bus.SCLK_IN = 1'b0;
  endtask
  task automatic spi_bits(input logic [7:0] tx, input int hi, input int lo, inout logic [7:0] rx);
    logic m;
    for (int i = hi; i >= lo; i--) begin
      bit_rise(tx[i], m);
      rx[i] = m;
      bit_fall();
    end
  endtask
  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    rx = '0;
    spi_bits(tx, 7, 0, rx);
  endtask
  task automatic select_t;
    bus.nSS = 1'b0;
    tick(8);
  endtask
  task automatic deselect_t;
    tick(8);
    bus.nSS = 1'b1;
    tick(8);
  endtask

  task automatic test_reset;
    logic [7:0] d, r;
    checks += 4;
    if (bus.MISO !== 1'b1) begin errors++; $display("FAIL reset_miso got %b want 1", bus.MISO); end
    if (bus.MISO_OE !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", bus.MISO_OE); end
    if (bus.RDATA !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", bus.RDATA); end
    if (bus.IRQ !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", bus.IRQ); end
    rst_n = 1'b1;
    tick(4);
    select_t();
    r = '0;
    spi_bits(8'hE0, 7, 5, r);
    checks++;
    if (bus.MISO_OE !== 1'b1) begin errors++; $display("FAIL midbyte_oe got %b want 1", bus.MISO_OE); end
    #2 rst_n = 1'b0; bus.nSS = 1'b1;
    #1;
    checks += 2;
    if (bus.MISO !== 1'b1) begin errors++; $display("FAIL midreset_miso got %b want 1", bus.MISO); end
    if (bus.MISO_OE !== 1'b0) begin errors++; $display("FAIL midreset_oe got %b want 0", bus.MISO_OE); end
    tick(2);
    rst_n = 1'b1;
    tick(4);
    cpu_read(A_STATUS, d);
    checks += 2;
    if (d !== 8'h02) begin errors++; $display("FAIL reset_status got %h want 02", d); end
    if (bus.IRQ !== 1'b0) begin errors++; $display("FAIL reset_irq2 got %b want 0", bus.IRQ); end
  endtask

  task automatic test_tx_rx;
    logic [7:0] m, d, e;
    cpu_write(A_DATA, 8'hA5);
    miso_exp.push_back(8'hA5);
    rx_exp.push_back(8'h3C);
    select_t();
    spi_byte(8'h3C, m);
    e = miso_exp.pop_front();
    checks++;
    if (m !== e) begin errors++; $display("FAIL txrx_miso got %h want %h", m, e); end
    tick(8);
    cpu_write(A_DATA, 8'hC3);
    miso_exp.push_back(8'hC3);
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 8'h09) begin errors++; $display("FAIL txrx_status got %h want 09", d); end
    cpu_read(A_DATA, d);
    e = rx_exp.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("FAIL txrx_data got %h want %h", d, e); end
    cpu_read(A_STATUS, d);
    checks++;
    if (d[ST_RXF] !== 1'b0) begin errors++; $display("FAIL txrx_rxf_clr got %b want 0", d[ST_RXF]); end
    deselect_t();
  endtask

  task automatic test_pending;
    logic [7:0] m, d, e;
    rx_exp.push_back(8'h00);
    select_t();
    spi_byte(8'h00, m);
    e = miso_exp.pop_front();
    checks++;
    if (m !== e) begin errors++; $display("FAIL pend_miso got %h want %h", m, e); end
    deselect_t();
    cpu_read(A_DATA, d);
    e = rx_exp.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("FAIL pend_data got %h want %h", d, e); end
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL pend_status got %h want 02", d); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] m, d, e;
    miso_exp.push_back(8'hFF);
    miso_exp.push_back(8'hFF);
    rx_exp.push_back(8'h11);
    select_t();
    spi_byte(8'h11, m);
    e = miso_exp.pop_front();
    checks++;
    if (m !== e) begin errors++; $display("FAIL b2b_miso0 got %h want %h", m, e); end
    spi_byte(8'h22, m);
    e = miso_exp.pop_front();
    checks++;
    if (m !== e) begin errors++; $display("FAIL b2b_miso1 got %h want %h", m, e); end
    deselect_t();
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 8'h07) begin errors++; $display("FAIL b2b_status got %h want 07", d); end
    cpu_read(A_DATA, d);
    e = rx_exp.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("FAIL b2b_data got %h want %h", d, e); end
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 8'h06) begin errors++; $display("FAIL b2b_ovr_kept got %h want 06", d); end
    cpu_write(A_STATUS, 8'h04);
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL b2b_ovr_clr got %h want 02", d); end
  endtask

  task automatic test_partial;
    logic [7:0] m, d, e;
    select_t();
    m = '0;
    spi_bits(8'hF0, 7, 3, m);
    bus.nSS = 1'b1;
    tick(LAT);
    checks += 2;
    if (bus.MISO_OE !== 1'b0) begin errors++; $display("FAIL partial_oe got %b want 0", bus.MISO_OE); end
    if (bus.MISO !== 1'b1) begin errors++; $display("FAIL partial_miso got %b want 1", bus.MISO); end
    tick(8);
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL partial_status got %h want 02", d); end
    miso_exp.push_back(8'hFF);
    rx_exp.push_back(8'h5A);
    select_t();
    spi_byte(8'h5A, m);
    e = miso_exp.pop_front();
    checks++;
    if (m !== e) begin errors++; $display("FAIL partial_miso2 got %h want %h", m, e); end
    deselect_t();
    cpu_read(A_DATA, d);
    e = rx_exp.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("FAIL partial_data got %h want %h", d, e); end
  endtask

  task automatic test_irq;
    logic [7:0] m, d, e;
    logic b;
    cpu_write(A_CTRL, 8'h01);
    cpu_read(A_CTRL, d);
    checks += 2;
    if (d !== 8'h01) begin errors++; $display("FAIL irq_ctrl got %h want 01", d); end
    if (bus.IRQ !== 1'b0) begin errors++; $display("FAIL irq_idle got %b want 0", bus.IRQ); end
    miso_exp.push_back(8'hFF);
    rx_exp.push_back(8'h77);
    select_t();
    m = '0;
    spi_bits(8'h77, 7, 1, m);
    bit_rise(1'b1, b);
    m[0] = b;
    tick(LAT);
    checks++;
    if (bus.IRQ !== 1'b0) begin errors++; $display("FAIL irq_early got %b want 0", bus.IRQ); end
    tick(1);
    checks++;
    if (bus.IRQ !== 1'b1) begin errors++; $display("FAIL irq_set got %b want 1", bus.IRQ); end
    tick(8 - LAT - 1);
    bus.SCLK_IN = 1'b0;
    e = miso_exp.pop_front();
    checks++;
    if (m !== e) begin errors++; $display("FAIL irq_miso got %h want %h", m, e); end
    cpu_read(A_DATA, d);
    e = rx_exp.pop_front();
    checks += 2;
    if (d !== e) begin errors++; $display("FAIL irq_data got %h want %h", d, e); end
    if (bus.IRQ !== 1'b1) begin errors++; $display("FAIL irq_hold got %b want 1", bus.IRQ); end
    tick(1);
    checks++;
    if (bus.IRQ !== 1'b0) begin errors++; $display("FAIL irq_clr got %b want 0", bus.IRQ); end
    deselect_t();
    cpu_write(A_CTRL, 8'h02);
    tick(1);
    checks++;
    if (bus.IRQ !== 1'b1) begin errors++; $display("FAIL irq_txe got %b want 1", bus.IRQ); end
    cpu_write(A_DATA, 8'h9C);
    miso_exp.push_back(8'h9C);
    tick(1);
    checks++;
    if (bus.IRQ !== 1'b0) begin errors++; $display("FAIL irq_txe_clr got %b want 0", bus.IRQ); end
    cpu_write(A_CTRL, 8'h00);
  endtask

  task automatic test_simultaneous;
    logic [7:0] m, d, e;
    logic b;
    rx_exp.push_back(8'h12);
    rx_exp.push_back(8'h34);
    miso_exp.push_back(8'hFF);
    select_t();
    spi_byte(8'h12, m);
    e = miso_exp.pop_front();
    checks++;
    if (m !== e) begin errors++; $display("FAIL sim_miso0 got %h want %h", m, e); end
    m = '0;
    spi_bits(8'h34, 7, 1, m);
    bit_rise(1'b0, b);
    m[0] = b;
    tick(LAT - 1);
    bus.ADDR = A_DATA;
    bus.RD_STB = 1'b1;
    tick(1);
    bus.RD_STB = 1'b0;
    d = bus.RDATA;
    e = rx_exp.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("FAIL sim_read got %h want %h", d, e); end
    tick(8 - LAT);
    bus.SCLK_IN = 1'b0;
    e = miso_exp.pop_front();
    checks++;
    if (m !== e) begin errors++; $display("FAIL sim_miso1 got %h want %h", m, e); end
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 8'h0B) begin errors++; $display("FAIL sim_status got %h want 0b", d); end
    cpu_read(A_DATA, d);
    e = rx_exp.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("FAIL sim_data got %h want %h", d, e); end
    deselect_t();
  endtask

  initial begin
    bus.SCLK_IN = 1'b0; bus.nSS = 1'b1; bus.MOSI_IN = 1'b0;
    bus.ADDR = '0; bus.WR_STB = 1'b0; bus.RD_STB = 1'b0; bus.WDATA = '0;
    #2 rst_n = 1'b0;
    tick(2);
    test_reset();
    test_tx_rx();
    test_pending();
    test_back_to_back();
    test_partial();
    test_irq();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI mode-0 responder (target) for the Kolibri board; the opposite end of the CPU's bit-banged SPI initiator (SCLK/MOSI/MISO/chip-select).
- Lets an external SPI master exchange bytes with the 6309 through a small register window.
- All SPI inputs are oversampled in the 48 MHz master-clock domain; the CPU side is a synchronous strobe interface decoded by the glue logic.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on SCLK_IN, nSS, MOSI_IN (minimum 2).
- DUMMY, 8'hFF: byte shifted out when no TX byte is pending.

Ports:
- MHZ48  input  1  master clock; sole clock.
- nRES  input  1  asynchronous active-low reset.
- SCLK_IN  input  1  SPI clock from external master, asynchronous.
- nSS  input  1  target select, active low, asynchronous.
- MOSI_IN  input  1  serial data from master.
- MISO  output  1  serial data to master.
- MISO_OE  output  1  MISO pad enable; 1 while selected.
- ADDR  input  2  register select.
- WR_STB  input  1  one-cycle write strobe.
- RD_STB  input  1  one-cycle read strobe.
- WDATA  input  8  write data.
- RDATA  output  8  read data, registered.
- IRQ  output  1  interrupt request, active high, level.

Behaviour:
- Reset (nRES=0, asynchronous, any time including mid-byte): MISO=1, MISO_OE=0, RDATA=0, IRQ=0. All buffers, bit counter, flags and IEN are cleared. TX_EMPTY reads 1.
- Synchronizer: inputs pass SYNC_STAGES flops, then one edge-detect flop. Internal event latency is SYNC_STAGES+1 cycles. Supported SCLK is at most MHZ48/8 with a minimum high/low time of 4 cycles.
- States:
  - IDLE: nSS_s=1. MISO_OE=0, bit_cnt=0.
  - On nSS_s falling -> SHIFT. Load tx_shift from tx_buf if tx_valid, else DUMMY; clear tx_valid. MISO_OE=1 and MISO=tx_shift[7] in the same cycle.
  - SHIFT, SCLK_s rising: rx_shift <= {rx_shift[6:0], MOSI_s}; bit_cnt++.
    - When bit_cnt goes 7->0: rx_data <= completed byte and RX_FULL=1.
    - If RX_FULL was already 1 and is not cleared in that same cycle: OVERRUN=1 and the new byte is dropped; rx_data keeps the old value.
  - SHIFT, SCLK_s falling:
    - If bit_cnt=0 (byte boundary), reload tx_shift from tx_buf or DUMMY and clear tx_valid.
    - Otherwise shift tx_shift left by one.
    - MISO always follows tx_shift[7].
  - nSS_s rising in any state -> IDLE. A partial byte is discarded (no RX_FULL, no OVERRUN); bit_cnt=0; MISO_OE=0 the same cycle; MISO=1.
- Register map (RDATA valid the cycle after RD_STB; otherwise holds its value):
  - ADDR 0 DATA:
    - Read returns rx_data and clears RX_FULL.
    - Write loads tx_buf and sets tx_valid; overwriting a pending byte is allowed and silent.
  - ADDR 1 STATUS:
    - Read bits: [0] RX_FULL, [1] TX_EMPTY (=~tx_valid), [2] OVERRUN, [3] SELECTED (~nSS_s), others 0.
    - Write 1 to bit 2 clears OVERRUN.
  - ADDR 2 CTRL (read/write): [0] IEN_RX, [1] IEN_TX, [2] IEN_OVR.
  - ADDR 3: reads 0; writes ignored.
- Simultaneous events:
  - DATA read in the same cycle as byte completion: completion wins; RX_FULL stays 1, rx_data is updated, no OVERRUN.
  - DATA write in the same cycle as a TX reload: the reload takes the old tx_buf or DUMMY; the new byte becomes pending (tx_valid=1).
  - OVERRUN clear in the same cycle as a new overrun: set wins.
- IRQ registered: (RX_FULL&IEN_RX)|(TX_EMPTY&IEN_TX)|(OVERRUN&IEN_OVR).

Decomposition:
- Package kolibri_spi_pkg holds:
  - register address constants (DATA, STATUS, CTRL);
  - STATUS and CTRL bit positions;
  - the state encoding (IDLE, SHIFT);
  - the default DUMMY constant.
- Sub-module spi_sync: parameterised synchronizer plus rise/fall edge detector, instantiated three times (SCLK_IN, nSS, MOSI_IN; edge outputs on SCLK and nSS only).

Test Plan:
- Reset mid-byte: select, 3 SCLK pulses, pulse nRES low -> MISO=1, MISO_OE=0, STATUS reads 8'h02, IRQ=0.
- Write DATA=8'hA5, master sends 8'h3C over 8 SCLK -> master samples 8'hA5 on MISO, STATUS=8'h09 while selected, DATA read returns 8'h3C, then STATUS bit0=0.
- No TX pending, two back-to-back bytes 8'h11, 8'h22 without reading -> master receives 8'hFF twice, DATA returns 8'h11, OVERRUN=1; writing STATUS 8'h04 clears OVERRUN.
- nSS deasserted after 5 bits of 8'hF0 -> RX_FULL stays 0, MISO_OE=0 within SYNC_STAGES+1 cycles; the next full byte 8'h5A is received correctly.
- CTRL=8'h01, byte 8'h77 received -> IRQ=1 one cycle after RX_FULL sets; DATA read -> IRQ=0 the following cycle.
- DATA read strobed in the same cycle as byte completion -> RX_FULL remains 1, new byte is readable, OVERRUN=0.
